// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sevenseg_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  localparam int unsigned NIBBLE_W = 4;
  localparam logic [63:0] AN_OFF   = '1;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Load handshake and blanking controls between the bus logic and the scan controller.
interface sevenseg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import sevenseg_pkg::*;

  logic                           load_valid;
  logic                           load_ready;
  logic [NIBBLE_W*NUM_DIGITS-1:0] load_value;
  logic [NUM_DIGITS-1:0]          blank_mask;

  modport master (output load_valid, load_value, blank_mask, input load_ready);
  modport slave  (input load_valid, load_value, blank_mask, output load_ready);

endinterface

// File: rtl/sevenseg_slot_timer.sv
// Slot counter and digit index; flags guard end, slot end and the cycle before frame end.
module sevenseg_slot_timer
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  output logic                         o_guard_end,
  output logic                         o_slot_end,
  output logic                         o_frame_pre,
  output logic [idx_w(NUM_DIGITS)-1:0] o_digit_nxt
);
  localparam int unsigned SW = $clog2(REFRESH_DIV);
  localparam int unsigned DW = idx_w(NUM_DIGITS);

  logic [SW-1:0] r_slot_cnt;
  logic [DW-1:0] r_digit_idx;
  logic          w_last_digit;

  assign w_last_digit = (r_digit_idx == DW'(NUM_DIGITS - 1));
  assign o_guard_end  = (r_slot_cnt == SW'(GUARD_CYCLES - 1));
  assign o_slot_end   = (r_slot_cnt == SW'(REFRESH_DIV - 1));
  // Lookahead so the registered frame_done lands on the last cycle of the last slot.
  assign o_frame_pre  = i_en && w_last_digit && (r_slot_cnt == SW'(REFRESH_DIV - 2));

  always_comb begin
    o_digit_nxt = r_digit_idx;
    if (!i_en) begin
      o_digit_nxt = '0;
    end else if (o_slot_end) begin
      o_digit_nxt = w_last_digit ? '0 : r_digit_idx + DW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else begin
      r_slot_cnt  <= o_slot_end ? '0 : r_slot_cnt + SW'(1);
      r_digit_idx <= o_digit_nxt;
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode display with a
// double-buffered value committed only at frame boundaries.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 500,
  parameter int unsigned LZ_SUPPRESS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  sevenseg_scan_ctrl_if.slave   load_if,
  output logic [NIBBLE_W-1:0]   seg_code,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_done
);
  localparam int unsigned DW = idx_w(NUM_DIGITS);
  localparam int unsigned VW = NIBBLE_W * NUM_DIGITS;

  scan_state_e           r_state, w_state_nxt;
  logic [VW-1:0]         r_active, r_pending, w_active_nxt;
  logic                  r_pend_full;
  logic                  w_guard_end, w_slot_end, w_frame_pre, w_commit, w_allz;
  logic [DW-1:0]         w_digit_nxt;
  logic [NUM_DIGITS-1:0] w_blank, w_an_nxt;
  logic [NIBBLE_W-1:0]   w_seg_nxt;

  sevenseg_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .o_guard_end(w_guard_end),
    .o_slot_end (w_slot_end),
    .o_frame_pre(w_frame_pre),
    .o_digit_nxt(w_digit_nxt)
  );

  assign load_if.load_ready = ~r_pend_full;
  assign w_commit           = frame_done && r_pend_full;
  assign w_active_nxt       = w_commit ? r_pending : r_active;

  always_ff @(posedge clk) begin
    if (rst) r_state <= GUARD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = GUARD;
    end else begin
      case (r_state)
        GUARD:   if (w_guard_end) w_state_nxt = ON;
        ON:      if (w_slot_end)  w_state_nxt = GUARD;
        default: w_state_nxt = GUARD;
      endcase
    end
  end

  // Outputs are computed from next-cycle state so the registered pins line up with the slot timing.
  always_comb begin
    w_allz    = 1'b1;
    w_blank   = '0;
    w_an_nxt  = AN_OFF[NUM_DIGITS-1:0];
    w_seg_nxt = '0;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      w_allz       = w_allz && (w_active_nxt[(i-1)*NIBBLE_W +: NIBBLE_W] == '0);
      w_blank[i-1] = load_if.blank_mask[i-1] || ((LZ_SUPPRESS != 0) && (i > 1) && w_allz);
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (DW'(i) == w_digit_nxt) begin
        w_seg_nxt = w_active_nxt[i*NIBBLE_W +: NIBBLE_W];
        if ((w_state_nxt == ON) && !w_blank[i]) w_an_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      seg_code    <= '0;
      an_n        <= AN_OFF[NUM_DIGITS-1:0];
      frame_done  <= 1'b0;
    end else begin
      r_active   <= w_active_nxt;
      seg_code   <= w_seg_nxt;
      an_n       <= w_an_nxt;
      frame_done <= w_frame_pre;
      if (w_commit) begin
        r_pend_full <= 1'b0;
      end else if (load_if.load_valid && !r_pend_full) begin
        r_pending   <= load_if.load_value;
        r_pend_full <= 1'b1;
      end
    end
  end

endmodule
